// File: rtl/arbitro_ula_4bits.sv
// Round-robin sequencer that shares one external 4-bit ALU between two requesters:
// accept a request, hold the ALU inputs for LAT cycles, capture result/flags, return a response.
module arbitro_ula_4bits #(
  parameter int LAT   = 1,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [3:0]       req0_a,
  input  logic [3:0]       req0_b,
  input  logic             req0_cin,
  input  logic [2:0]       req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [3:0]       req1_a,
  input  logic [3:0]       req1_b,
  input  logic             req1_cin,
  input  logic [2:0]       req1_op,
  output logic [3:0]       ula_A,
  output logic [3:0]       ula_B,
  output logic             ula_Cin,
  output logic [2:0]       ula_OP,
  input  logic [7:0]       ula_result,
  input  logic             ula_cout,
  input  logic             ula_ov,
  input  logic             ula_z,
  input  logic             ula_err,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [7:0]       rsp_result,
  output logic [3:0]       rsp_flags,
  output logic             busy,
  output logic [CNT_W-1:0] ops_done,
  output logic [1:0]       dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // valid never waits on ready, ready may depend combinationally on valid.
  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_CAPTURE, S_RESP} state_t;

  localparam logic [3:0]       LAT_M1  = 4'(LAT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [2:0]       OP_INV  = 3'd7;

  state_t           r_state;
  state_t           w_next;
  logic             r_last_grant;
  logic [3:0]       r_cnt;
  logic [3:0]       r_ula_a;
  logic [3:0]       r_ula_b;
  logic             r_ula_cin;
  logic [2:0]       r_ula_op;
  logic             r_rsp_valid;
  logic             r_rsp_id;
  logic [7:0]       r_rsp_result;
  logic [3:0]       r_rsp_flags;
  logic [CNT_W-1:0] r_ops;

  logic             w_grant0;
  logic             w_grant1;
  logic             w_accept;
  logic [3:0]       w_sel_a;
  logic [3:0]       w_sel_b;
  logic             w_sel_cin;
  logic [2:0]       w_sel_op;

  // On a tie the requester that did not win last time is served.
  assign w_grant0 = (r_state == S_IDLE) && !rst && req0_valid && (!req1_valid ||  r_last_grant);
  assign w_grant1 = (r_state == S_IDLE) && !rst && req1_valid && (!req0_valid || !r_last_grant);
  assign w_accept = w_grant0 | w_grant1;

  assign w_sel_a   = w_grant1 ? req1_a   : req0_a;
  assign w_sel_b   = w_grant1 ? req1_b   : req0_b;
  assign w_sel_cin = w_grant1 ? req1_cin : req0_cin;
  assign w_sel_op  = w_grant1 ? req1_op  : req0_op;

  assign req0_ready = w_grant0;
  assign req1_ready = w_grant1;
  assign ula_A      = r_ula_a;
  assign ula_B      = r_ula_b;
  assign ula_Cin    = r_ula_cin;
  assign ula_OP     = r_ula_op;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_id     = r_rsp_id;
  assign rsp_result = r_rsp_result;
  assign rsp_flags  = r_rsp_flags;
  assign ops_done   = r_ops;
  assign busy       = (r_state != S_IDLE);
  assign dbg_state  = r_state;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (w_accept) w_next = (w_sel_op == OP_INV) ? S_RESP : S_SETTLE;
      S_SETTLE:  if (r_cnt == 4'd0) w_next = S_CAPTURE;
      S_CAPTURE: w_next = S_RESP;
      S_RESP:    if (rsp_ready) w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_last_grant <= 1'b1;
      r_cnt        <= 4'd0;
      r_ula_a      <= 4'd0;
      r_ula_b      <= 4'd0;
      r_ula_cin    <= 1'b0;
      r_ula_op     <= 3'd0;
      r_rsp_valid  <= 1'b0;
      r_rsp_id     <= 1'b0;
      r_rsp_result <= 8'd0;
      r_rsp_flags  <= 4'd0;
      r_ops        <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_rsp_id     <= w_grant1;
            r_last_grant <= w_grant1;
            r_cnt        <= LAT_M1;
            // An invalid opcode never reaches the ALU; it is answered as an error at once.
            if (w_sel_op == OP_INV) begin
              r_rsp_valid  <= 1'b1;
              r_rsp_result <= 8'd0;
              r_rsp_flags  <= 4'b1000;
            end else begin
              r_ula_a   <= w_sel_a;
              r_ula_b   <= w_sel_b;
              r_ula_cin <= w_sel_cin;
              r_ula_op  <= w_sel_op;
            end
          end
        end
        S_SETTLE: begin
          if (r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
        end
        S_CAPTURE: begin
          r_rsp_valid  <= 1'b1;
          r_rsp_result <= ula_result;
          r_rsp_flags  <= {ula_err, ula_z, ula_ov, ula_cout};
        end
        S_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            if (r_ops != '1) r_ops <= r_ops + CNT_ONE;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_arbitro_ula_4bits.sv
// Bench for arbitro_ula_4bits: a behavioural ALU that only answers after its inputs have been
// stable long enough, a cycle-level transaction model with an expected queue, and directed phases.
module tb_arbitro_ula_4bits;

  localparam int LAT   = 4;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             req0_valid = 1'b0, req1_valid = 1'b0;
  logic             req0_ready, req1_ready;
  logic [3:0]       req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic             req0_cin = 1'b0, req1_cin = 1'b0;
  logic [2:0]       req0_op = '0, req1_op = '0;
  logic [3:0]       ula_A, ula_B;
  logic             ula_Cin;
  logic [2:0]       ula_OP;
  logic [7:0]       ula_result;
  logic             ula_cout, ula_ov, ula_z, ula_err;
  logic             rsp_valid, rsp_id;
  logic             rsp_ready = 1'b0;
  logic [7:0]       rsp_result;
  logic [3:0]       rsp_flags;
  logic             busy;
  logic [CNT_W-1:0] ops_done;
  logic [1:0]       dbg_state;

  arbitro_ula_4bits #(.LAT(LAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_cin(req0_cin), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_cin(req1_cin), .req1_op(req1_op),
    .ula_A(ula_A), .ula_B(ula_B), .ula_Cin(ula_Cin), .ula_OP(ula_OP),
    .ula_result(ula_result), .ula_cout(ula_cout), .ula_ov(ula_ov), .ula_z(ula_z), .ula_err(ula_err),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_flags(rsp_flags),
    .busy(busy), .ops_done(ops_done), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Returns {err, z, ov, cout, result[7:0]} computed with plain integer arithmetic.
  function automatic logic [11:0] alu(input logic [3:0] a, input logic [3:0] b,
                                      input logic cin, input logic [2:0] op);
    int sa, sb, s, ss;
    logic [7:0] r;
    logic co, ov, er;
    sa = a[3] ? int'(a) - 16 : int'(a);
    sb = b[3] ? int'(b) - 16 : int'(b);
    r = 8'd0; co = 1'b0; ov = 1'b0; er = 1'b0;
    case (op)
      3'd0: begin
        s = int'(a) + int'(b) + int'(cin);
        ss = sa + sb + int'(cin);
        r = 8'(s & 15); co = (s > 15); ov = (ss > 7) || (ss < -8);
      end
      3'd1: begin
        s = int'(a) - int'(b) - int'(cin);
        ss = sa - sb - int'(cin);
        r = 8'(s & 15); co = (s < 0); ov = (ss > 7) || (ss < -8);
      end
      3'd2: r = {4'd0, a & b};
      3'd3: r = {4'd0, a | b};
      3'd4: r = {4'd0, a ^ b};
      3'd5: r = 8'(int'(a) * int'(b));
      3'd6: if (b == 4'd0) er = 1'b1; else r = 8'(int'(a) / int'(b));
      default: er = 1'b1;
    endcase
    return {er, (r == 8'd0), ov, co, r};
  endfunction

  // ALU stand-in: output is garbage until the inputs have been stable for LAT+1 cycles.
  int         age = 0;
  logic [11:0] prev_in = 'x;
  logic [11:0] cur_in;
  logic [11:0] w_alu;

  always @(negedge clk) begin
    cur_in = {ula_A, ula_B, ula_Cin, ula_OP};
    if (cur_in !== prev_in) age = 1;
    else if (age < 15) age++;
    prev_in = cur_in;
  end

  always_comb begin
    w_alu = alu(ula_A, ula_B, ula_Cin, ula_OP);
    if (age < LAT + 1) w_alu = {4'b0101, 8'hEE};
  end
  assign ula_result = w_alu[7:0];
  assign {ula_err, ula_z, ula_ov, ula_cout} = w_alu[11:8];

  // ---------------- reference model / scoreboard ----------------
  logic [12:0]      exp_q[$];
  logic             m_idle = 1'b1, m_last = 1'b1, m_pend = 1'b0, m_after_rst = 1'b1;
  int               cyc = 0, m_due = 0;
  logic [CNT_W-1:0] m_ops = '0;
  logic [3:0]       m_a = '0, m_b = '0;
  logic             m_cin = 1'b0;
  logic [2:0]       m_op = '0;
  logic             e_r0, e_r1, e_rv, gid, gcin;
  logic [3:0]       ga, gb;
  logic [2:0]       gop;
  logic [11:0]      ar;

  logic             d_acc0 = 1'b0, d_acc1 = 1'b0;
  logic             d_grants[$];
  logic [12:0]      rsp_log[$];
  logic [7:0]       last_res = '0;
  logic [3:0]       last_flags = '0;
  logic             last_id = 1'b0;

  always @(negedge clk) begin
    cyc++;
    e_r0 = m_idle && !rst && req0_valid && (!req1_valid ||  m_last);
    e_r1 = m_idle && !rst && req1_valid && (!req0_valid || !m_last);
    e_rv = m_pend && (cyc >= m_due);
    chk("req0_ready", req0_ready, e_r0);
    chk("req1_ready", req1_ready, e_r1);
    chk("busy", busy, !m_idle);
    chk("ops_done", ops_done, m_ops);
    chk("ula_A", ula_A, m_a);
    chk("ula_B", ula_B, m_b);
    chk("ula_Cin", ula_Cin, m_cin);
    chk("ula_OP", ula_OP, m_op);
    chk("rsp_valid", rsp_valid, e_rv);
    if (e_rv && exp_q.size() > 0) begin
      chk("rsp_id", rsp_id, exp_q[0][12]);
      chk("rsp_result", rsp_result, exp_q[0][7:0]);
      chk("rsp_flags", rsp_flags, exp_q[0][11:8]);
    end
    if (m_after_rst) begin
      chk("rst_rsp_result", rsp_result, 0);
      chk("rst_rsp_flags", rsp_flags, 0);
      chk("rst_rsp_id", rsp_id, 0);
      m_after_rst = 1'b0;
    end
    // observed handshakes, used by the driver and the directed checks
    if (req0_valid && req0_ready) begin d_acc0 = 1'b1; d_grants.push_back(1'b0); end
    if (req1_valid && req1_ready) begin d_acc1 = 1'b1; d_grants.push_back(1'b1); end
    if (rsp_valid && rsp_ready) begin
      last_res = rsp_result; last_flags = rsp_flags; last_id = rsp_id;
      rsp_log.push_back({rsp_id, rsp_flags, rsp_result});
    end
    // advance the model for the next cycle
    if (rst) begin
      m_idle = 1'b1; m_last = 1'b1; m_pend = 1'b0; m_ops = '0;
      m_a = '0; m_b = '0; m_cin = 1'b0; m_op = '0;
      exp_q.delete(); m_after_rst = 1'b1;
    end else if (e_rv && rsp_ready) begin
      void'(exp_q.pop_front());
      m_pend = 1'b0; m_idle = 1'b1;
      if (m_ops != '1) m_ops = m_ops + 1'b1;
    end else if (e_r0 || e_r1) begin
      gid  = e_r1;
      ga   = gid ? req1_a : req0_a;
      gb   = gid ? req1_b : req0_b;
      gcin = gid ? req1_cin : req0_cin;
      gop  = gid ? req1_op : req0_op;
      ar   = (gop == 3'd7) ? {4'b1000, 8'h00} : alu(ga, gb, gcin, gop);
      exp_q.push_back({gid, ar});
      m_idle = 1'b0; m_pend = 1'b1; m_last = gid;
      m_due = cyc + ((gop == 3'd7) ? 1 : LAT + 2);
      if (gop != 3'd7) begin m_a = ga; m_b = gb; m_cin = gcin; m_op = gop; end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic set0(input logic [3:0] a, input logic [3:0] b, input logic cin, input logic [2:0] op);
    d_acc0 = 1'b0; req0_a = a; req0_b = b; req0_cin = cin; req0_op = op; req0_valid = 1'b1;
  endtask

  task automatic set1(input logic [3:0] a, input logic [3:0] b, input logic cin, input logic [2:0] op);
    d_acc1 = 1'b0; req1_a = a; req1_b = b; req1_cin = cin; req1_op = op; req1_valid = 1'b1;
  endtask

  task automatic wait_acc0();
    for (int k = 0; k < 40 && !d_acc0; k++) step();
    chk("acc0_timeout", d_acc0, 1);
    d_acc0 = 1'b0;
  endtask

  task automatic wait_acc1();
    for (int k = 0; k < 40 && !d_acc1; k++) step();
    chk("acc1_timeout", d_acc1, 1);
    d_acc1 = 1'b0;
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 60 && (busy || rsp_valid); k++) step();
    chk("idle_timeout", busy, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1; step(); step(); rst = 1'b0;
  endtask

  // ---------------- directed and random phases ----------------
  initial begin
    do_reset();

    // A: single add 7+5
    rsp_ready = 1'b1;
    set0(4'd7, 4'd5, 1'b0, 3'd0);
    wait_acc0();
    req0_valid = 1'b0;
    chk("A_ula_A", ula_A, 7);
    chk("A_ula_B", ula_B, 5);
    wait_idle();
    chk("A_result", last_res, 8'd12);
    chk("A_flags", last_flags, 4'b0010);
    chk("A_id", last_id, 0);
    chk("A_ops", ops_done, 1);

    // B: both requesters valid from reset
    req0_a = 4'd3; req0_b = 4'd4; req0_cin = 1'b0; req0_op = 3'd5; req0_valid = 1'b1;
    req1_a = 4'd2; req1_b = 4'd5; req1_cin = 1'b0; req1_op = 3'd1; req1_valid = 1'b1;
    do_reset();
    d_grants.delete(); rsp_log.delete();
    for (int k = 0; k < 200 && d_grants.size() < 4; k++) step();
    req0_valid = 1'b0; req1_valid = 1'b0;
    wait_idle();
    chk("B_ngrants", d_grants.size(), 4);
    chk("B_nrsp", rsp_log.size(), 4);
    if (d_grants.size() >= 4 && rsp_log.size() >= 4) begin
      for (int k = 0; k < 4; k++) begin
        chk("B_grant", d_grants[k], k % 2);
        chk("B_rsp", rsp_log[k], (k % 2 == 0) ? 13'h000C : 13'h110D);
      end
    end

    // C: invalid opcode from requester 1
    set1(4'd9, 4'd9, 1'b1, 3'd7);
    wait_acc1();
    req1_valid = 1'b0;
    wait_idle();
    chk("C_result", last_res, 0);
    chk("C_flags", last_flags, 4'b1000);
    chk("C_id", last_id, 1);
    chk("C_ula_OP", ula_OP, 1);
    chk("C_ula_A", ula_A, 2);
    chk("C_ops", ops_done, 5);

    // D: divide by zero, response held off while requester 1 waits
    rsp_ready = 1'b0;
    set0(4'd9, 4'd0, 1'b0, 3'd6);
    wait_acc0();
    req0_valid = 1'b0;
    set1(4'd1, 4'd1, 1'b0, 3'd0);
    for (int k = 0; k < 40 && !rsp_valid; k++) step();
    chk("D_rsp_timeout", rsp_valid, 1);
    for (int k = 0; k < 5; k++) begin
      step();
      chk("D_hold_valid", rsp_valid, 1);
      chk("D_hold_err", rsp_flags[3], 1);
      chk("D_req1_wait", req1_ready, 0);
    end
    rsp_ready = 1'b1;
    wait_acc1();
    req1_valid = 1'b0;
    wait_idle();

    // E: reset pulse in the middle of SETTLE
    set0(4'd1, 4'd2, 1'b0, 3'd0);
    wait_acc0();
    req0_valid = 1'b0;
    step();
    chk("E_in_settle", busy, 1);
    rst = 1'b1;
    set0(4'd4, 4'd4, 1'b0, 3'd0);
    step();
    rst = 1'b0;
    chk("E_busy", busy, 0);
    chk("E_rsp_valid", rsp_valid, 0);
    chk("E_ula_A", ula_A, 0);
    chk("E_ops", ops_done, 0);
    wait_acc0();
    req0_valid = 1'b0;
    wait_idle();
    chk("E_result", last_res, 8'd8);
    chk("E_ops_after", ops_done, 1);

    // F: random traffic, abandoned requests and random response back-pressure
    for (int k = 0; k < 400; k++) begin
      if (d_acc0) begin d_acc0 = 1'b0; req0_valid = 1'b0; end
      if (d_acc1) begin d_acc1 = 1'b0; req1_valid = 1'b0; end
      if (!req0_valid && $urandom_range(0, 1) == 1)
        set0(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
      else if (req0_valid && $urandom_range(0, 7) == 0) req0_valid = 1'b0;
      if (!req1_valid && $urandom_range(0, 1) == 1)
        set1(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
      else if (req1_valid && $urandom_range(0, 7) == 0) req1_valid = 1'b0;
      rsp_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
    wait_idle();

    // G: back-to-back adds drive the counter into saturation
    for (int k = 0; k < 260; k++) begin
      set0(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 3'd0);
      wait_acc0();
    end
    req0_valid = 1'b0;
    wait_idle();
    chk("G_ops_sat", ops_done, 8'hFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
